// File: rtl/riscv_pkg.sv
// Shared pipeline constants: writeback result-select encodings and datapath widths.
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

endpackage

// File: rtl/writeback_regfile_if.sv
// MEM/WB writeback bus plus the decode-stage read ports and the forwarding/counter outputs.
interface writeback_regfile_if
  import riscv_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int ADDR_W = REG_AW
);

  logic              RegWriteW;
  logic [1:0]        ResultSrcW;
  logic [DATA_W-1:0] ALUResultW;
  logic [DATA_W-1:0] ReadDataW;
  logic [DATA_W-1:0] PCPlus4W;
  logic [ADDR_W-1:0] RdW;
  logic [ADDR_W-1:0] A1D;
  logic [ADDR_W-1:0] A2D;
  logic [DATA_W-1:0] RD1D;
  logic [DATA_W-1:0] RD2D;
  logic [DATA_W-1:0] ResultW;
  logic [31:0]       WrCount;

  modport master (
    output RegWriteW, ResultSrcW, ALUResultW, ReadDataW, PCPlus4W, RdW, A1D, A2D,
    input  RD1D, RD2D, ResultW, WrCount
  );

  modport slave (
    input  RegWriteW, ResultSrcW, ALUResultW, ReadDataW, PCPlus4W, RdW, A1D, A2D,
    output RD1D, RD2D, ResultW, WrCount
  );

endinterface

// File: rtl/regfile_core.sv
// Register array with one write port and two raw read ports; x0 always reads zero.
module regfile_core #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] regs [2**ADDR_W];

  // Reset clears every entry so reads never expose X; x0 is simply never written.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2**ADDR_W; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/writeback_regfile.sv
// Writeback stage: result select, register commit, same-cycle read bypass and write counter.
module writeback_regfile
  import riscv_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int ADDR_W = REG_AW
) (
  input logic               clk,
  input logic               rst,
  writeback_regfile_if.slave bus
);

  logic [DATA_W-1:0] result;
  logic [DATA_W-1:0] raw1;
  logic [DATA_W-1:0] raw2;
  logic [31:0]       wr_count;
  logic              we;

  always_comb begin
    result = '0;
    case (bus.ResultSrcW)
      RES_ALU: result = bus.ALUResultW;
      RES_MEM: result = bus.ReadDataW;
      RES_PC4: result = bus.PCPlus4W;
      default: result = '0;
    endcase
  end

  // Gating with rst also suppresses the bypass while reset is asserted.
  assign we = rst & bus.RegWriteW & (bus.RdW != '0);

  regfile_core #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (bus.RdW),
    .wdata (result),
    .raddr1(bus.A1D),
    .raddr2(bus.A2D),
    .rdata1(raw1),
    .rdata2(raw2)
  );

  always_ff @(posedge clk) begin
    if (!rst) wr_count <= '0;
    else if (we) wr_count <= wr_count + 32'd1;
  end

  assign bus.RD1D    = (bus.A1D == '0) ? '0 : ((we && bus.RdW == bus.A1D) ? result : raw1);
  assign bus.RD2D    = (bus.A2D == '0) ? '0 : ((we && bus.RdW == bus.A2D) ? result : raw2);
  assign bus.ResultW = result;
  assign bus.WrCount = wr_count;

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed checks of result select, commit, bypass, x0, reset and counter wrap.
module tb_writeback_regfile;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  writeback_regfile_if bus ();

  writeback_regfile dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0;
    bus.RegWriteW  = 1'b1;
    bus.ResultSrcW = 2'b00;
    bus.ALUResultW = 32'h0000_1234;
    bus.ReadDataW  = 32'h0;
    bus.PCPlus4W   = 32'h0;
    bus.RdW        = 5'd5;
    bus.A1D        = 5'd5;
    bus.A2D        = 5'd5;

    // 1: reset held two clocks with a write pending
    tick();
    #1 check("bypass_in_reset", bus.RD1D, 32'h0);
    tick();
    rst = 1'b1;
    bus.RegWriteW = 1'b0;
    #1;
    check("reset_rd1_x5", bus.RD1D, 32'h0);
    check("reset_rd2_x5", bus.RD2D, 32'h0);
    check("reset_wrcount", bus.WrCount, 32'h0);

    // 2: result select
    bus.ALUResultW = 32'h11;
    bus.ReadDataW  = 32'h22;
    bus.PCPlus4W   = 32'h33;
    bus.RdW = 5'd3;
    bus.A1D = 5'd3;
    bus.ResultSrcW = 2'b11;
    #1 check("result_rsv", bus.ResultW, 32'h0);
    bus.ResultSrcW = 2'b00;
    bus.RegWriteW = 1'b1;
    #1 check("result_alu", bus.ResultW, 32'h11);
    tick();
    bus.RegWriteW = 1'b0;
    #1 check("x3_alu", bus.RD1D, 32'h11);
    bus.ResultSrcW = 2'b01;
    bus.RegWriteW = 1'b1;
    #1 check("result_mem", bus.ResultW, 32'h22);
    tick();
    bus.RegWriteW = 1'b0;
    #1 check("x3_mem", bus.RD1D, 32'h22);
    bus.ResultSrcW = 2'b10;
    bus.RegWriteW = 1'b1;
    #1 check("result_pc4", bus.ResultW, 32'h33);
    tick();
    bus.RegWriteW = 1'b0;
    #1;
    check("x3_pc4", bus.RD1D, 32'h33);
    check("wrcount_3", bus.WrCount, 32'd3);

    // 3: same-cycle bypass on both ports
    bus.ResultSrcW = 2'b00;
    bus.ALUResultW = 32'hDEAD_BEEF;
    bus.RdW = 5'd7;
    bus.A1D = 5'd7;
    bus.A2D = 5'd7;
    bus.RegWriteW = 1'b1;
    #1;
    check("bypass_rd1", bus.RD1D, 32'hDEAD_BEEF);
    check("bypass_rd2", bus.RD2D, 32'hDEAD_BEEF);
    tick();
    bus.RegWriteW = 1'b0;
    #1;
    check("x7_rd1", bus.RD1D, 32'hDEAD_BEEF);
    check("x7_rd2", bus.RD2D, 32'hDEAD_BEEF);
    check("wrcount_4", bus.WrCount, 32'd4);

    // 4: x0 writes are dropped
    bus.ALUResultW = 32'hFFFF_FFFF;
    bus.RdW = 5'd0;
    bus.A1D = 5'd0;
    bus.A2D = 5'd3;
    bus.RegWriteW = 1'b1;
    #1 check("x0_before", bus.RD1D, 32'h0);
    tick();
    #1;
    check("x0_after", bus.RD1D, 32'h0);
    check("x3_kept", bus.RD2D, 32'h33);
    check("wrcount_x0", bus.WrCount, 32'd4);

    // 5: reset arriving mid-operation discards the concurrent write
    bus.ALUResultW = 32'h55;
    bus.RdW = 5'd9;
    bus.A1D = 5'd9;
    tick();
    #1 check("x9_written", bus.RD1D, 32'h55);
    bus.ALUResultW = 32'h66;
    bus.RdW = 5'd10;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    bus.RegWriteW = 1'b0;
    bus.A1D = 5'd9;
    bus.A2D = 5'd10;
    #1;
    check("midreset_x9", bus.RD1D, 32'h0);
    check("midreset_x10", bus.RD2D, 32'h0);
    check("midreset_wrcount", bus.WrCount, 32'h0);
    bus.A1D = 5'd7;
    #1 check("midreset_x7", bus.RD1D, 32'h0);

    // 6: counter wrap
    force dut.wr_count = 32'hFFFF_FFFF;
    #1 check("wrcount_forced", bus.WrCount, 32'hFFFF_FFFF);
    release dut.wr_count;
    bus.ALUResultW = 32'h0000_A5A5;
    bus.RdW = 5'd1;
    bus.A1D = 5'd1;
    bus.RegWriteW = 1'b1;
    tick();
    bus.RegWriteW = 1'b0;
    #1;
    check("wrap_x1", bus.RD1D, 32'h0000_A5A5);
    check("wrap_wrcount", bus.WrCount, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
